// File: rtl/posit_encoder_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// posit_encoder_seq_if : start/done handshake and data bundle for the packer
// Revision: 1.0
// ----------------------------------------------------------------------------
interface posit_encoder_seq_if #(
  parameter int POSIT_WIDTH = 8,
  parameter int FRAC_WIDTH  = 8,
  parameter int SCALE_WIDTH = 6
);
  logic                   start;
  logic                   sign;
  logic                   zero_in;
  logic                   nar_in;
  logic [SCALE_WIDTH-1:0] scale;
  logic [FRAC_WIDTH-1:0]  frac;
  logic                   done;
  logic                   zero;
  logic [POSIT_WIDTH-1:0] result;

  modport master (
    output start, sign, zero_in, nar_in, scale, frac,
    input  done, zero, result
  );

  modport slave (
    input  start, sign, zero_in, nar_in, scale, frac,
    output done, zero, result
  );
endinterface
`default_nettype wire

// File: rtl/posit_encoder_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// posit_encoder_seq : serial posit packer (regime, exponent, fraction, RNE)
// Revision: 1.0
// ----------------------------------------------------------------------------
module posit_encoder_seq #(
  parameter int POSIT_WIDTH = 8,
  parameter int ES          = 1,
  parameter int FRAC_WIDTH  = 8,
  parameter int SCALE_WIDTH = 6
) (
  input  logic                clk,
  input  logic                reset,
  posit_encoder_seq_if.slave  bus
);

  localparam int N     = POSIT_WIDTH;
  localparam int SRC_W = ES + FRAC_WIDTH;
  localparam int CNT_W = $clog2(N + 1);
  localparam int REG_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PREP  = 2'd1,
    S_SHIFT = 2'd2,
    S_ROUND = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   sign_q;
  logic                   zero_in_q;
  logic                   nar_q;
  logic [SCALE_WIDTH-1:0] scale_q;
  logic [FRAC_WIDTH-1:0]  frac_q;
  logic [SRC_W-1:0]       src_q;
  logic [N-1:0]           coll_q;
  logic [REG_W-1:0]       reg_cnt_q;
  logic                   reg_bit_q;
  logic                   reg_term_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic                   done_q;
  logic                   zero_q;
  logic [N-1:0]           result_q;

  logic signed [SCALE_WIDTH-1:0] k_d;
  int                            k_int_d;
  logic [ES-1:0]                 e_d;
  logic                          big_d;
  logic                          tiny_d;
  logic [REG_W-1:0]              reg_cnt_init_d;
  logic                          shift_bit_d;
  logic                          round_up_d;
  logic [N-1:0]                  body_d;
  logic [N-1:0]                  packed_d;
  logic [N-1:0]                  maxpos_d;
  logic [N-1:0]                  minpos_d;

  always_comb begin
    k_d            = $signed(scale_q) >>> ES;
    k_int_d        = int'(k_d);
    e_d            = scale_q[ES-1:0];
    big_d          = (k_int_d >= N - 2);
    tiny_d         = (k_int_d <= -(N - 1));
    // Run length of the repeated regime bit; the terminator is tracked separately.
    reg_cnt_init_d = (k_int_d >= 0) ? REG_W'(k_int_d + 1) : REG_W'(-k_int_d);
    maxpos_d       = {1'b0, {(N-1){1'b1}}};
    minpos_d       = {{(N-1){1'b0}}, 1'b1};
  end

  always_comb begin
    shift_bit_d = src_q[SRC_W-1];
    if (reg_cnt_q != '0) begin
      shift_bit_d = reg_bit_q;
    end else if (reg_term_q) begin
      shift_bit_d = ~reg_bit_q;
    end
  end

  // coll_q = {body[N-2:0], guard}; whatever remains in src_q forms the sticky bit.
  always_comb begin
    round_up_d = coll_q[0] & (coll_q[1] | (|src_q));
    body_d     = {1'b0, coll_q[N-1:1]} + {{(N-1){1'b0}}, round_up_d};
    packed_d   = sign_q ? -body_d : body_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sign_q     <= 1'b0;
      zero_in_q  <= 1'b0;
      nar_q      <= 1'b0;
      scale_q    <= '0;
      frac_q     <= '0;
      src_q      <= '0;
      coll_q     <= '0;
      reg_cnt_q  <= '0;
      reg_bit_q  <= 1'b0;
      reg_term_q <= 1'b0;
      bit_cnt_q  <= '0;
      done_q     <= 1'b0;
      zero_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            sign_q    <= bus.sign;
            zero_in_q <= bus.zero_in;
            nar_q     <= bus.nar_in;
            scale_q   <= bus.scale;
            frac_q    <= bus.frac;
            state_q   <= S_PREP;
          end
        end
        S_PREP: begin
          if (nar_q) begin
            result_q <= {1'b1, {(N-1){1'b0}}};
            zero_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_IDLE;
          end else if (zero_in_q) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= S_IDLE;
          end else if (big_d || tiny_d) begin
            // Saturate instead of rounding to zero or NaR.
            result_q <= big_d ? (sign_q ? -maxpos_d : maxpos_d)
                              : (sign_q ? -minpos_d : minpos_d);
            zero_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            src_q      <= {e_d, frac_q};
            reg_cnt_q  <= reg_cnt_init_d;
            reg_bit_q  <= ~k_d[SCALE_WIDTH-1];
            reg_term_q <= 1'b1;
            coll_q     <= '0;
            bit_cnt_q  <= '0;
            state_q    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          coll_q <= {coll_q[N-2:0], shift_bit_d};
          if (reg_cnt_q != '0) begin
            reg_cnt_q <= reg_cnt_q - REG_W'(1);
          end else if (reg_term_q) begin
            reg_term_q <= 1'b0;
          end else begin
            src_q <= {src_q[SRC_W-2:0], 1'b0};
          end
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(N - 1)) begin
            state_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          result_q <= packed_d;
          zero_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.done   = done_q;
  assign bus.zero   = zero_q;
  assign bus.result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_posit_encoder_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_posit_encoder_seq : scoreboard bench for the serial posit packer
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_posit_encoder_seq;

  localparam int N  = 8;
  localparam int ES = 1;
  localparam int FW = 8;
  localparam int SW = 6;

  typedef struct {
    logic [7:0] res;
    logic       z;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  posit_encoder_seq_if #(.POSIT_WIDTH(N), .FRAC_WIDTH(FW), .SCALE_WIDTH(SW)) bus ();

  posit_encoder_seq #(
    .POSIT_WIDTH (N),
    .ES          (ES),
    .FRAC_WIDTH  (FW),
    .SCALE_WIDTH (SW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference encoder: builds the full bit string, then rounds to nearest even.
  function automatic exp_t model(input logic s, input logic z, input logic nr,
                                 input logic [5:0] sc, input logic [7:0] fr);
    exp_t r;
    int   k;
    bit   q[$];
    logic [7:0] mag;
    logic g, st;
    k     = int'($signed(sc)) >>> 1;
    r.z   = 1'b0;
    r.lat = 1;
    if (nr) r.res = 8'h80;
    else if (z) begin r.res = 8'h00; r.z = 1'b1; end
    else if (k >= 6) r.res = s ? 8'h81 : 8'h7F;
    else if (k <= -7) r.res = s ? 8'hFF : 8'h01;
    else begin
      r.lat = 10;
      if (k >= 0) begin repeat (k + 1) q.push_back(1'b1); q.push_back(1'b0); end
      else begin repeat (-k) q.push_back(1'b0); q.push_back(1'b1); end
      q.push_back(sc[0]);
      for (int i = 7; i >= 0; i--) q.push_back(fr[i]);
      mag = 8'h00;
      for (int i = 0; i < 7; i++) mag = {mag[6:0], q[i]};
      g  = q[7];
      st = 1'b0;
      for (int i = 8; i < q.size(); i++) st = st | q[i];
      if (g && (mag[0] || st)) mag = mag + 8'd1;
      r.res = s ? -mag : mag;
    end
    return r;
  endfunction

  task automatic drive(input logic s, input logic z, input logic nr,
                       input logic [5:0] sc, input logic [7:0] fr);
    bus.sign = s; bus.zero_in = z; bus.nar_in = nr; bus.scale = sc; bus.frac = fr;
  endtask

  task automatic accept();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic [7:0] res, output logic z);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.done && lat < 40);
    res = bus.result;
    z   = bus.zero;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (bus.done !== 1'b0 || bus.zero !== 1'b0 || bus.result !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: got done=%b zero=%b result=%h, need 0/0/00", bus.done, bus.zero, bus.result);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_done: got %b need 0", bus.done);
    end
  endtask

  task automatic test_normal();
    logic       s [13] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic [5:0] sc[13] = '{6'h00, 6'h00, 6'h03, 6'h03, 6'h00, 6'h00, 6'h3F, 6'h0B, 6'h0B, 6'h34, 6'h34, 6'h00, 6'h00};
    logic [7:0] fr[13] = '{8'h00, 8'h00, 8'h80, 8'h80, 8'h18, 8'h28, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'hF8, 8'h2C};
    logic [7:0] rs[13] = '{8'h40, 8'hC0, 8'h6C, 8'h94, 8'h42, 8'h42, 8'h30, 8'h7E, 8'h7F, 8'h01, 8'hFF, 8'h50, 8'h43};
    int lat; logic [7:0] res; logic z; exp_t e;
    for (int i = 0; i < 13; i++) begin
      drive(s[i], 1'b0, 1'b0, sc[i], fr[i]);
      sb.push_back('{res: rs[i], z: 1'b0, lat: 10});
      accept();
      wait_done(lat, res, z);
      e = sb.pop_front();
      n_checks++;
      if (res !== e.res || z !== e.z || lat != e.lat) begin
        n_fail++;
        $display("FAIL normal[%0d]: got result=%h zero=%b lat=%0d, need %h/%b/%0d", i, res, z, lat, e.res, e.z, e.lat);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL normal_pulse[%0d]: done=%b one cycle after done, need 0", i, bus.done);
      end
    end
  endtask

  task automatic test_fast();
    logic       s [8] = '{0, 1, 0, 0, 1, 0, 0, 0};
    logic       zi[8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    logic       nr[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    logic [5:0] sc[8] = '{6'h14, 6'h14, 6'h0C, 6'h2C, 6'h2C, 6'h32, 6'h00, 6'h00};
    logic [7:0] rs[8] = '{8'h7F, 8'h81, 8'h7F, 8'h01, 8'hFF, 8'h01, 8'h00, 8'h80};
    logic       zf[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    int lat; logic [7:0] res; logic z; exp_t e;
    for (int i = 0; i < 8; i++) begin
      drive(s[i], zi[i], nr[i], sc[i], 8'hA5);
      sb.push_back('{res: rs[i], z: zf[i], lat: 1});
      accept();
      wait_done(lat, res, z);
      e = sb.pop_front();
      n_checks++;
      if (res !== e.res || z !== e.z || lat != e.lat) begin
        n_fail++;
        $display("FAIL fast[%0d]: got result=%h zero=%b lat=%0d, need %h/%b/%0d", i, res, z, lat, e.res, e.z, e.lat);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic       s [6] = '{0, 0, 1, 0, 1, 0};
    logic       zi[6] = '{0, 0, 0, 1, 0, 0};
    logic [5:0] sc[6] = '{6'h03, 6'h14, 6'h00, 6'h00, 6'h3F, 6'h2C};
    logic [7:0] fr[6] = '{8'h80, 8'h00, 8'h18, 8'h00, 8'h55, 8'h00};
    int lat; logic [7:0] res; logic z; exp_t e;
    drive(s[0], zi[0], 1'b0, sc[0], fr[0]);
    sb.push_back(model(s[0], zi[0], 1'b0, sc[0], fr[0]));
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      wait_done(lat, res, z);
      e = sb.pop_front();
      n_checks++;
      if (res !== e.res || z !== e.z || lat != e.lat) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got result=%h zero=%b lat=%0d, need %h/%b/%0d", i, res, z, lat, e.res, e.z, e.lat);
      end
      if (i < 5) begin
        drive(s[i+1], zi[i+1], 1'b0, sc[i+1], fr[i+1]);
        sb.push_back(model(s[i+1], zi[i+1], 1'b0, sc[i+1], fr[i+1]));
        @(posedge clk); #1;
      end else begin
        bus.start = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int lat; int extra; logic [7:0] res; logic z; exp_t e;
    drive(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    sb.push_back(model(1'b0, 1'b0, 1'b0, 6'h00, 8'h00));
    accept();
    lat = 0;
    do begin
      if (lat == 3) begin drive(1'b1, 1'b0, 1'b0, 6'h14, 8'hFF); bus.start = 1'b1; end
      else bus.start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end while (!bus.done && lat < 40);
    bus.start = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (bus.result !== e.res || bus.zero !== e.z || lat != e.lat) begin
      n_fail++;
      $display("FAIL ignore_start: got result=%h zero=%b lat=%0d, need %h/%b/%0d", bus.result, bus.zero, lat, e.res, e.z, e.lat);
    end
    extra = 0;
    repeat (14) begin @(posedge clk); #1; if (bus.done) extra++; end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL ignore_start_extra_done: got %0d pulses, need 0", extra);
    end
  endtask

  task automatic test_input_change();
    int lat; logic [7:0] res; logic z; exp_t e;
    drive(1'b0, 1'b0, 1'b0, 6'h03, 8'h80);
    sb.push_back(model(1'b0, 1'b0, 1'b0, 6'h03, 8'h80));
    accept();
    drive(1'b1, 1'b1, 1'b1, 6'h2C, 8'hFF);
    wait_done(lat, res, z);
    e = sb.pop_front();
    n_checks++;
    if (res !== e.res || z !== e.z || lat != e.lat) begin
      n_fail++;
      $display("FAIL input_change: got result=%h zero=%b lat=%0d, need %h/%b/%0d", res, z, lat, e.res, e.z, e.lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat; int extra; logic [7:0] res; logic z; exp_t e;
    drive(1'b1, 1'b0, 1'b0, 6'h03, 8'h80);
    accept();
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (bus.done !== 1'b0 || bus.zero !== 1'b0 || bus.result !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid: got done=%b zero=%b result=%h, need 0/0/00", bus.done, bus.zero, bus.result);
    end
    extra = 0;
    repeat (12) begin @(posedge clk); #1; if (bus.done) extra++; end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL reset_mid_stray_done: got %0d pulses, need 0", extra);
    end
    drive(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
    sb.push_back('{res: 8'h40, z: 1'b0, lat: 10});
    accept();
    wait_done(lat, res, z);
    e = sb.pop_front();
    n_checks++;
    if (res !== e.res || z !== e.z || lat != e.lat) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got result=%h zero=%b lat=%0d, need %h/%b/%0d", res, z, lat, e.res, e.z, e.lat);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_fast();
    test_back_to_back();
    test_ignore_start();
    test_input_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
